// File: rtl/pb_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, polarity normalisation and a
// four-state debounce FSM that produces a clean level plus press, release and
// long-press strobes. Every output is a flop; button_raw only reaches the FSM
// through the synchroniser.
module pb_debounce #(
  parameter int unsigned STABLE_CYCLES  = 50000,
  parameter int unsigned LONG_CYCLES    = 50000000,
  parameter bit          RAW_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W          = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic button_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    StReleased,
    StConfirmPress,
    StPressed,
    StConfirmRelease
  } state_e;

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(LONG_CYCLES);
  // Wraps to all-ones when LONG_CYCLES is 0; never used then because of LongEn.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_CYCLES - 1);
  localparam bit               LongEn   = (LONG_CYCLES != 0);

  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic             pressed;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] deb_cnt_d, deb_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q;
  logic             hold_step;
  logic             button_db_d, button_db_q;
  logic             press_pulse_d, press_pulse_q;
  logic             release_pulse_d, release_pulse_q;
  logic             long_press_d, long_press_q;

  // Synchroniser next values and the normalised "1 = pressed" level.
  always_comb begin
    s1_d    = button_raw;
    s2_d    = s1_q;
    pressed = s2_q ^ RAW_ACTIVE_LOW;
  end

  // Synchroniser flops; reset loads the released pin level so no false press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= RAW_ACTIVE_LOW;
      s2_q <= RAW_ACTIVE_LOW;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StReleased;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      button_db_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      button_db_q     <= button_db_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
    end
  end

  // Hold counter advances while logically pressed and saturates at LONG_CYCLES.
  assign hold_step = ((state_q == StPressed) || (state_q == StConfirmRelease)) &&
                     (hold_cnt_q != HoldMax);

  // Next-state logic: each confirm state restarts or advances its window.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_step ? hold_cnt_q + 1'b1 : hold_cnt_q;
    unique case (state_q)
      StReleased: begin
        if (pressed) begin
          state_d   = StConfirmPress;
          deb_cnt_d = '0;
        end
      end
      StConfirmPress: begin
        if (!pressed) begin
          state_d = StReleased;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StPressed;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!pressed) begin
          state_d   = StConfirmRelease;
          deb_cnt_d = '0;
        end
      end
      StConfirmRelease: begin
        // Returning to StPressed keeps hold_cnt so a glitch does not restart long-press.
        if (pressed) begin
          state_d = StPressed;
        end else if (deb_cnt_q == DebLast) begin
          state_d = StReleased;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = StReleased;
    endcase
  end

  // Output next values, decoded from the transition taken this cycle.
  always_comb begin
    button_db_d     = (state_d == StPressed) || (state_d == StConfirmRelease);
    press_pulse_d   = (state_q == StConfirmPress) && (state_d == StPressed);
    release_pulse_d = (state_q == StConfirmRelease) && (state_d == StReleased);
    long_press_d    = LongEn && hold_step && (hold_cnt_q == HoldLast);
  end

  assign button_db     = button_db_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce with STABLE_CYCLES=4, LONG_CYCLES=10, active-low pin.
// Expected strobes (kind*100000 + edge number) are queued when stimulus is
// driven; a negedge monitor logs observed strobes; each scenario drains both.
module tb_pb_debounce;

  localparam int KPress = 1;
  localparam int KRel   = 2;
  localparam int KLong  = 3;
  localparam int KScale = 100000;

  logic clk = 1'b0;
  logic reset_n;
  logic button_raw;
  logic button_db;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];
  int obs_rd = 0;
  int press_edge = 0;

  pb_debounce #(
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (10),
    .RAW_ACTIVE_LOW(1'b1),
    .CNT_W         (26)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_raw   (button_raw),
    .button_db    (button_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  // Edge counter: cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse === 1'b1)   obs_q.push_back(KPress * KScale + cyc);
    if (release_pulse === 1'b1) obs_q.push_back(KRel * KScale + cyc);
    if (long_press === 1'b1)    obs_q.push_back(KLong * KScale + cyc);
  end

  task automatic test_reset();
    int ev_exp, ev_obs;
    reset_n = 1'b0;
    button_raw = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if ({button_db, press_pulse, release_pulse, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000",
               {button_db, press_pulse, release_pulse, long_press});
    end
    reset_n = 1'b1;
    repeat (10) begin @(negedge clk); #1; end
    checks++;
    if ({button_db, press_pulse, release_pulse, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 0000",
               {button_db, press_pulse, release_pulse, long_press});
    end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL reset_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  task automatic test_clean_press();
    int k, r, ev_exp, ev_obs;
    logic want;
    @(negedge clk); #1;
    k = cyc + 1;
    button_raw = 1'b0;
    exp_q.push_back(KPress * KScale + k + 6);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      want = (cyc >= k + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL clean_press_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    checks++;
    if (press_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clean_press_width: got %b required 0", press_pulse);
    end
    r = cyc + 1;
    button_raw = 1'b1;
    exp_q.push_back(KRel * KScale + r + 6);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      want = (cyc < r + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL clean_release_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    repeat (2) begin @(negedge clk); #1; end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL clean_press_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  // Leaves the button held; press_edge records the accepted press.
  task automatic test_bounce();
    int k, ev_exp, ev_obs;
    logic want;
    @(negedge clk); #1;
    button_raw = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    button_raw = 1'b1;
    @(negedge clk); #1;
    k = cyc + 1;
    button_raw = 1'b0;
    press_edge = k + 6;
    exp_q.push_back(KPress * KScale + press_edge);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      want = (cyc >= k + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL bounce_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    repeat (2) begin @(negedge clk); #1; end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL bounce_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  task automatic test_long_press();
    int r, ev_exp, ev_obs;
    logic want;
    exp_q.push_back(KLong * KScale + press_edge + 10);
    for (int i = 0; i < 40 && cyc < press_edge + 14; i++) begin
      @(negedge clk); #1;
      want = (cyc == press_edge + 10);
      checks++;
      if (long_press !== want) begin
        errors++;
        $display("FAIL long_press edge %0d: got %b required %b", cyc, long_press, want);
      end
    end
    r = cyc + 1;
    button_raw = 1'b1;
    exp_q.push_back(KRel * KScale + r + 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      want = (cyc < r + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL long_release_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL long_press_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  task automatic test_release_glitch();
    int k, r, ev_exp, ev_obs;
    logic want;
    @(negedge clk); #1;
    k = cyc + 1;
    button_raw = 1'b0;
    exp_q.push_back(KPress * KScale + k + 6);
    repeat (8) begin @(negedge clk); #1; end
    button_raw = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    button_raw = 1'b0;
    // Long-press still measured from the original acceptance at k+6.
    exp_q.push_back(KLong * KScale + k + 16);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      checks++;
      if (button_db !== 1'b1) begin
        errors++;
        $display("FAIL glitch_db edge %0d: got %b required 1", cyc, button_db);
      end
    end
    r = cyc + 1;
    button_raw = 1'b1;
    exp_q.push_back(KRel * KScale + r + 6);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      want = (cyc < r + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL glitch_release_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL glitch_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  task automatic test_reset_mid_confirm();
    int k, m, r, ev_exp, ev_obs;
    logic want;
    @(negedge clk); #1;
    k = cyc + 1;
    button_raw = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    // FSM is in the press confirm window (deb_cnt = 1) here.
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({button_db, press_pulse, release_pulse, long_press} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_confirm_reset edge %0d: got %b required 0000", cyc,
               {button_db, press_pulse, release_pulse, long_press});
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
    m = cyc + 1;
    exp_q.push_back(KPress * KScale + m + 6);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      want = (cyc >= m + 6);
      checks++;
      if (button_db !== want) begin
        errors++;
        $display("FAIL post_reset_db edge %0d: got %b required %b", cyc, button_db, want);
      end
    end
    r = cyc + 1;
    button_raw = 1'b1;
    exp_q.push_back(KRel * KScale + r + 6);
    repeat (9) begin @(negedge clk); #1; end
    checks++;
    if (k + 4 != m - 2) begin
      errors++;
      $display("FAIL reset_timing_setup: got %0d required %0d", m - 2, k + 4);
    end
    while (exp_q.size() != 0 || obs_rd < obs_q.size()) begin
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      ev_obs = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 0;
      if (obs_rd < obs_q.size()) obs_rd++;
      checks++;
      if (ev_obs !== ev_exp) begin
        errors++;
        $display("FAIL reset_mid_strobe: got %0d required %0d", ev_obs, ev_exp);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    button_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_reset_mid_confirm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
